// File: rtl/icache_nway_pkg.sv
// Shared encodings for the n-way instruction cache: trace commands,
// next-level commands, controller states and a saturating counter helper.
package icache_nway_pkg;

    localparam logic [3:0] CMD_CLEAR = 4'd8;
    localparam logic [3:0] CMD_INVAL = 4'd3;
    localparam logic [3:0] CMD_FETCH = 4'd2;
    localparam logic [3:0] CMD_PRINT = 4'd9;

    localparam logic [1:0] NL_IDLE = 2'b00;
    localparam logic [1:0] NL_READ = 2'b01;

    typedef enum logic [1:0] {
        ST_SWEEP     = 2'd0,
        ST_IDLE      = 2'd1,
        ST_MISS_WAIT = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_nway_plru_tree.sv
// Binary-tree pseudo-LRU: victim selection and post-access update.
// Node i has children 2i+1 (lower half) and 2i+2 (upper half).
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         bits,
    input  logic [$clog2(WAYS)-1:0] way,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic [WAYS-2:0]         bits_next
);

    localparam int WB = $clog2(WAYS);

    always_comb begin
        int node;
        victim = '0;
        node   = 0;
        for (int l = 0; l < WB; l++) begin
            victim[WB-1-l] = bits[node];
            node = 2 * node + 1 + int'(bits[node]);
        end
    end

    // Each node on the accessed path is pointed at the opposite half.
    always_comb begin
        int node;
        bits_next = bits;
        node      = 0;
        for (int l = 0; l < WB; l++) begin
            bits_next[node] = ~way[WB-1-l];
            node = 2 * node + 1 + int'(way[WB-1-l]);
        end
    end

endmodule

// File: rtl/icache_nway.sv
// Trace-driven n-way set-associative instruction cache model with
// tree-PLRU replacement, single outstanding line read and statistics.
module icache_nway
    import icache_nway_pkg::*;
#(
    parameter int WAYS        = 4,
    parameter int INDEX_BITS  = 14,
    parameter int OFFSET_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              n,
    input  logic [31:0]             add_in,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [31-OFFSET_BITS:0] add_out,
    output logic [1:0]              cmd_out,
    input  logic                    mem_ack,
    output logic [31:0]             hit,
    output logic [31:0]             miss,
    output logic [31:0]             reads
);

    localparam int SETS     = 2 ** INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int WB       = $clog2(WAYS);
    localparam int LA       = 32 - OFFSET_BITS;

    logic [TAG_BITS-1:0] tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]     valid_mem [SETS];
    logic [WAYS-2:0]     plru_mem  [SETS];

    state_t                state;
    logic [INDEX_BITS-1:0] sweep_idx;
    logic [LA-1:0]         line_q;
    logic [1:0]            cmd_q;

    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] idx;
    logic [WAYS-1:0]       valid_rd;
    logic [WAYS-2:0]       plru_rd;
    logic [WAYS-1:0]       hit_vec;
    logic                  hit_any;
    logic [WB-1:0]         hit_way;
    logic [WB-1:0]         free_way;
    logic [WB-1:0]         plru_victim;
    logic [WB-1:0]         victim_way;
    logic [WB-1:0]         access_way;
    logic [WAYS-2:0]       plru_upd;
    logic                  accept;
    logic                  do_fetch;
    logic                  do_inval;
    logic                  fill;

    assign tag      = add_in[31 -: TAG_BITS];
    assign idx      = add_in[OFFSET_BITS +: INDEX_BITS];
    assign valid_rd = valid_mem[idx];
    assign plru_rd  = plru_mem[idx];

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_rd[w] && (tag_mem[idx][w] == tag);
        end
    end

    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WB'(w);
            if (!valid_rd[w]) free_way = WB'(w);
        end
    end

    assign hit_any    = |hit_vec;
    assign victim_way = (&valid_rd) ? plru_victim : free_way;
    assign access_way = hit_any ? hit_way : victim_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .bits      (plru_rd),
        .way       (access_way),
        .victim    (plru_victim),
        .bits_next (plru_upd)
    );

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign do_fetch  = accept && (n == CMD_FETCH);
    assign do_inval  = accept && (n == CMD_INVAL);
    assign fill      = do_fetch && !hit_any;

    logic                  v_we;
    logic [INDEX_BITS-1:0] v_idx;
    logic [WAYS-1:0]       v_data;
    logic                  p_we;
    logic [INDEX_BITS-1:0] p_idx;
    logic [WAYS-2:0]       p_data;

    // One write port per array, shared between sweep and lookups.
    always_comb begin
        v_we   = 1'b0;
        v_idx  = idx;
        v_data = valid_rd;
        p_we   = 1'b0;
        p_idx  = idx;
        p_data = plru_upd;
        if (state == ST_SWEEP) begin
            v_we   = 1'b1;
            v_idx  = sweep_idx;
            v_data = '0;
            p_we   = 1'b1;
            p_idx  = sweep_idx;
            p_data = '0;
        end else if (do_fetch) begin
            p_we = 1'b1;
            if (!hit_any) begin
                v_we   = 1'b1;
                v_data = valid_rd | (WAYS'(1) << victim_way);
            end
        end else if (do_inval && hit_any) begin
            v_we   = 1'b1;
            v_data = valid_rd & ~hit_vec;
        end
    end

    always_ff @(posedge clk) begin
        if (v_we) valid_mem[v_idx] <= v_data;
        if (p_we) plru_mem[p_idx] <= p_data;
        if (fill) tag_mem[idx][victim_way] <= tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SWEEP;
            sweep_idx <= '0;
            hit       <= '0;
            miss      <= '0;
            reads     <= '0;
            cmd_q     <= NL_IDLE;
            line_q    <= '0;
        end else begin
            case (state)
                ST_SWEEP: begin
                    if (sweep_idx == INDEX_BITS'(SETS - 1)) begin
                        state     <= ST_IDLE;
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        case (n)
                            CMD_CLEAR: begin
                                hit       <= '0;
                                miss      <= '0;
                                reads     <= '0;
                                sweep_idx <= '0;
                                state     <= ST_SWEEP;
                            end
                            CMD_FETCH: begin
                                reads <= sat_inc(reads);
                                if (hit_any) begin
                                    hit <= sat_inc(hit);
                                end else begin
                                    miss   <= sat_inc(miss);
                                    line_q <= add_in[31:OFFSET_BITS];
                                    cmd_q  <= NL_READ;
                                    state  <= ST_MISS_WAIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MISS_WAIT: begin
                    if (mem_ack) begin
                        cmd_q <= NL_IDLE;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_SWEEP;
            endcase
        end
    end

    assign cmd_out = cmd_q;
    assign add_out = (cmd_q == NL_READ) ? line_q : 'z;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && accept && n == CMD_PRINT) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (valid_mem[s][w]) begin
                        $display("icache set %0d plru %b way %0d tag %h",
                                 s, plru_mem[s], w, tag_mem[s][w]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Scoreboard bench for icache_nway: read requests are checked by a monitor
// against a queue of expected line addresses; counters checked per command.
module tb_icache_nway;
    import icache_nway_pkg::*;

    localparam int SETS = 2 ** 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  n = 4'd0;
    logic [31:0] add_in = 32'd0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    wire  [25:0] add_out;
    logic [1:0]  cmd_out;
    logic        mem_ack = 1'b0;
    logic [31:0] hit, miss, reads;

    int checks = 0;
    int failures = 0;
    int e_hit = 0;
    int e_miss = 0;
    int e_reads = 0;
    logic [25:0] exp_q [$];
    logic [25:0] exp_line;
    logic [1:0]  prev_cmd = 2'b00;

    icache_nway dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .n         (n),
        .add_in    (add_in),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .add_out   (add_out),
        .cmd_out   (cmd_out),
        .mem_ack   (mem_ack),
        .hit       (hit),
        .miss      (miss),
        .reads     (reads)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_hit"}, hit, e_hit);
        chk({tag, "_miss"}, miss, e_miss);
        chk({tag, "_reads"}, reads, e_reads);
    endtask

    always @(negedge clk) begin
        if (rst_n && cmd_out == NL_READ && prev_cmd != NL_READ) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_req actual=%h required=none", add_out);
            end else begin
                exp_line = exp_q.pop_front();
                chk("req_addr", 32'(add_out), 32'(exp_line));
            end
        end
        prev_cmd = cmd_out;
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] a);
        int k = 0;
        @(posedge clk);
        #1;
        n = c;
        add_in = a;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int k = 0;
        while (!cmd_ready && k < SETS + 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, k, SETS);
    endtask

    task automatic serve(input logic [25:0] line, input int hold);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_cmd", 32'(cmd_out), 32'(NL_READ));
            chk("hold_addr", 32'(add_out), 32'(line));
            chk("hold_ready", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("ack_ready", 32'(cmd_ready), 32'd1);
        chk("ack_cmd", 32'(cmd_out), 32'(NL_IDLE));
    endtask

    task automatic fetch(input logic [31:0] a, input bit is_miss,
                         input int hold);
        e_reads++;
        if (is_miss) begin
            e_miss++;
            exp_q.push_back(a[31:6]);
        end else begin
            e_hit++;
        end
        issue(CMD_FETCH, a);
        if (is_miss) serve(a[31:6], hold);
        chk_counters("fetch");
    endtask

    initial begin
        #2;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_cmd", 32'(cmd_out), 32'(NL_IDLE));
        chk_counters("rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("sweep_len");
        chk_counters("post_sweep");

        fetch(32'h0000_0000, 1'b1, 1);
        fetch(32'h0010_0000, 1'b1, 1);
        fetch(32'h0020_0000, 1'b1, 1);
        fetch(32'h0030_0000, 1'b1, 1);
        fetch(32'h0000_0000, 1'b0, 0);
        fetch(32'h0010_0000, 1'b0, 0);
        fetch(32'h0020_0000, 1'b0, 0);
        fetch(32'h0030_0000, 1'b0, 0);
        fetch(32'h0040_0000, 1'b1, 1);
        fetch(32'h0000_0000, 1'b1, 1);

        fetch(32'h0000_0040, 1'b1, 10);

        issue(CMD_INVAL, 32'h0010_0000);
        chk_counters("inval");
        fetch(32'h0010_0000, 1'b1, 1);
        issue(CMD_INVAL, 32'h0070_0000);
        chk_counters("inval_absent");
        fetch(32'h0030_0000, 1'b0, 0);

        issue(CMD_PRINT, 32'h0);
        issue(4'd5, 32'h0030_0000);
        chk_counters("ignored");
        chk("ignored_ready", 32'(cmd_ready), 32'd1);

        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("stray_ack_cmd", 32'(cmd_out), 32'(NL_IDLE));
        chk("stray_ack_ready", 32'(cmd_ready), 32'd1);

        issue(CMD_CLEAR, 32'h0);
        e_hit = 0;
        e_miss = 0;
        e_reads = 0;
        chk_counters("clear");
        chk("clear_ready", 32'(cmd_ready), 32'd0);
        wait_ready("clear_sweep_len");
        fetch(32'h0030_0000, 1'b1, 1);

        exp_q.push_back(26'h20000);
        issue(CMD_FETCH, 32'h0080_0000);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        e_hit = 0;
        e_miss = 0;
        e_reads = 0;
        chk("midrst_cmd", 32'(cmd_out), 32'(NL_IDLE));
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        chk_counters("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("midrst_sweep_len");
        chk("no_reissue", 32'(cmd_out), 32'(NL_IDLE));
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
